// File: rtl/mcm_mode_sched_if.sv
// mcm_mode_sched_if: handshake/bus bundle for the CDC mode scheduler.
// Signals:
//   en, cmp_done, cmp_rel[1:0]  global enable and latched frequency-compare result
//   vld_in, sdata_in, mdata_in  traffic to be classified
//   busy_in[4:0]                per-engine busy (pulse, level, edge, dmux, fifo)
//   sel_oh[4:0], mode[2:0]      one-hot engine enable and encoded mode
//   clk_en_out, err             engine clock-gate request, sticky illegal-traffic flag
//   switch_cnt[7:0]             completed mode switches
// Modports: master drives the inputs (traffic side), slave is the scheduler.
interface mcm_mode_sched_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic             cmp_done;
    logic [1:0]       cmp_rel;
    logic             vld_in;
    logic             sdata_in;
    logic [WIDTH-1:0] mdata_in;
    logic [4:0]       busy_in;
    logic [4:0]       sel_oh;
    logic [2:0]       mode;
    logic             clk_en_out;
    logic             err;
    logic [7:0]       switch_cnt;

    modport master (
        output en, cmp_done, cmp_rel, vld_in, sdata_in, mdata_in, busy_in,
        input  sel_oh, mode, clk_en_out, err, switch_cnt
    );

    modport slave (
        input  en, cmp_done, cmp_rel, vld_in, sdata_in, mdata_in, busy_in,
        output sel_oh, mode, clk_en_out, err, switch_cnt
    );
endinterface

// File: rtl/mcm_mode_sched.sv
// mcm_mode_sched: transmit-domain mode scheduler for the multimode CDC
// synchronizer. Classifies traffic, picks one engine (pulse, level, edge,
// dmux, fifo), switches break-before-make with a drain handshake and drops
// the engine clock-gate request after an idle timeout.
// Ports:
//   clk_a    transmit-domain clock
//   rst_n_a  asynchronous active-low reset
//   bus      mcm_mode_sched_if.slave (inputs en..busy_in, registered outputs)
// Optional feature macro: MCM_SWITCH_CNT_EN (saturating switch counter;
// switch_cnt tied to 0 when undefined).
module mcm_mode_sched #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic            clk_a,
    input  logic            rst_n_a,
    mcm_mode_sched_if.slave bus
);
    localparam int unsigned NENG = 5;
    localparam int unsigned MW   = 3;
    localparam int unsigned TW   = 8;

    localparam logic [MW-1:0] M_NONE  = 3'd0;
    localparam logic [MW-1:0] M_PULSE = 3'd1;
    localparam logic [MW-1:0] M_LEVEL = 3'd2;
    localparam logic [MW-1:0] M_EDGE  = 3'd3;
    localparam logic [MW-1:0] M_DMUX  = 3'd4;
    localparam logic [MW-1:0] M_FIFO  = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_READY, S_WAKE, S_ACTIVE, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   tgt_q, tgt_d, cur_q, cur_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NENG-1:0] sel_q, sel_d;
    logic [MW-1:0]   mode_q, mode_d;
    logic            clk_en_q, clk_en_d;
    logic            err_q, err_d;
    logic            sw_inc;

    logic [WIDTH-1:0] mdata;
    logic             mnz, s_req, m_req, mv_req, any_req, illegal;
    logic             go_off, busy_cur, tgt_vld;
    logic [MW-1:0]    target;

    function automatic logic [NENG-1:0] onehot(input logic [MW-1:0] m);
        logic [NENG-1:0] r;
        r = '0;
        case (m)
            M_PULSE: r = 5'b00001;
            M_LEVEL: r = 5'b00010;
            M_EDGE:  r = 5'b00100;
            M_DMUX:  r = 5'b01000;
            M_FIFO:  r = 5'b10000;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Traffic classification
    assign mdata    = bus.mdata_in;
    assign mnz      = |mdata;
    assign s_req    = bus.sdata_in & ~mnz & ~bus.vld_in;
    assign m_req    = ~bus.sdata_in & mnz & ~bus.vld_in;
    assign mv_req   = ~bus.sdata_in & mnz & bus.vld_in;
    assign any_req  = s_req | m_req | mv_req;
    assign illegal  = bus.sdata_in & mnz;
    assign go_off   = ~bus.en | ~bus.cmp_done;
    assign busy_cur = |(bus.busy_in & onehot(cur_q));

    // Target mode lookup from traffic class and frequency relation
    always_comb begin
        target = M_NONE;
        if (bus.cmp_done && (bus.cmp_rel != 2'b00)) begin
            if (s_req) begin
                case (bus.cmp_rel)
                    2'b01:   target = M_PULSE;
                    2'b10:   target = M_LEVEL;
                    default: target = M_EDGE;
                endcase
            end else if (m_req) begin
                target = M_FIFO;
            end else if (mv_req) begin
                target = M_DMUX;
            end
        end
    end
    assign tgt_vld = (target != M_NONE);

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        timer_d = '0;
        sw_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.en && bus.cmp_done) state_d = S_READY;
            end
            S_READY: begin
                if (!bus.cmp_done) begin
                    state_d = S_IDLE;
                end else if (bus.en && tgt_vld) begin
                    tgt_d   = target;
                    state_d = S_WAKE;
                end
            end
            S_WAKE: begin
                if (go_off) begin
                    tgt_d   = M_NONE;
                    state_d = S_READY;
                end else begin
                    cur_d   = tgt_q;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (go_off) begin
                    tgt_d   = M_NONE;
                    state_d = S_DRAIN;
                end else if (tgt_vld && (target != cur_q)) begin
                    tgt_d   = target;
                    state_d = S_DRAIN;
                end else if (!any_req && !busy_cur) begin
                    if (timer_q == TW'(IDLE_TIMEOUT - 1)) begin
                        cur_d   = M_NONE;
                        state_d = S_READY;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (go_off)       tgt_d = M_NONE;
                else if (tgt_vld) tgt_d = target;
                if (!go_off && tgt_vld && (target == cur_q)) begin
                    // Traffic came back to the engine being drained: cancel
                    state_d = S_ACTIVE;
                end else if (!busy_cur) begin
                    if (tgt_d == M_NONE) begin
                        // Shutdown drain: release engine
                        cur_d   = M_NONE;
                        state_d = bus.cmp_done ? S_READY : S_IDLE;
                    end else begin
                        state_d = S_WAKE;
                        sw_inc  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        sel_d    = ((state_d == S_ACTIVE) || (state_d == S_DRAIN)) ? onehot(cur_d) : '0;
        mode_d   = (sel_d != '0) ? cur_d : M_NONE;
        clk_en_d = (state_d == S_WAKE) || (state_d == S_ACTIVE) || (state_d == S_DRAIN);
        err_d    = err_q | illegal;
    end

    // State and output registers
    always_ff @(posedge clk_a or negedge rst_n_a) begin
        if (!rst_n_a) begin
            state_q  <= S_IDLE;
            tgt_q    <= M_NONE;
            cur_q    <= M_NONE;
            timer_q  <= '0;
            sel_q    <= '0;
            mode_q   <= M_NONE;
            clk_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cur_q    <= cur_d;
            timer_q  <= timer_d;
            sel_q    <= sel_d;
            mode_q   <= mode_d;
            clk_en_q <= clk_en_d;
            err_q    <= err_d;
        end
    end

    assign bus.sel_oh     = sel_q;
    assign bus.mode       = mode_q;
    assign bus.clk_en_out = clk_en_q;
    assign bus.err        = err_q;

`ifdef MCM_SWITCH_CNT_EN
    logic [7:0] cnt_q;

    // Saturating count of completed switches
    always_ff @(posedge clk_a or negedge rst_n_a) begin
        if (!rst_n_a)                      cnt_q <= '0;
        else if (sw_inc && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
    end
    assign bus.switch_cnt = cnt_q;
`else
    logic unused_sw_inc;
    assign unused_sw_inc  = sw_inc;
    assign bus.switch_cnt = '0;
`endif
endmodule
